// File: rtl/apb_if.sv
// Bus bundle for the DFE coefficient register slave.
//   MTRANS  - transfer request
//   MWRITE  - 1 = write, 0 = read
//   MSELx   - one-hot component select
//   MADDR   - register address
//   MWDATA  - signed write data
//   MRDATA  - read data returned by the slave
interface apb_if #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned PDATA_WIDTH = 32,
  parameter int unsigned COEFF_WIDTH = 20,
  parameter int unsigned COMP        = 4
);
  logic                          MTRANS;
  logic                          MWRITE;
  logic [COMP-1:0]               MSELx;
  logic [ADDR_WIDTH-1:0]         MADDR;
  logic signed [COEFF_WIDTH-1:0] MWDATA;
  logic [PDATA_WIDTH-1:0]        MRDATA;

  modport master (
    output MTRANS, MWRITE, MSELx, MADDR, MWDATA,
    input  MRDATA
  );

  modport slave (
    input  MTRANS, MWRITE, MSELx, MADDR, MWDATA,
    output MRDATA
  );
endinterface

// File: rtl/apb.sv
// Register-file slave for the DFE filter array.
// Holds the fractional-decimator taps, three IIR coefficient banks, the CIC ratio
// and control fields; drives them in parallel to the filter chain.
//   clk, rst         - clock, synchronous active-high reset
//   bus              - request/readback bundle (slave side)
//   *_OUT            - coefficient / control fields
//   *_VLD            - one-cycle pulse after a write to a bank's last address
// Each transfer runs IDLE/ACCESS -> SETUP -> ACCESS; only latched request fields
// are used to read or commit.
module apb #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned PDATA_WIDTH = 32,
  parameter int unsigned COEFF_WIDTH = 20,
  parameter int unsigned N_TAP       = 72,
  parameter int unsigned NUM_DENUM   = 5,
  parameter int unsigned COMP        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  apb_if.slave                          bus,
  output logic signed [COEFF_WIDTH-1:0] FRAC_DECI_OUT [N_TAP],
  output logic                          FRAC_DECI_VLD,
  output logic signed [COEFF_WIDTH-1:0] IIR_24_OUT [NUM_DENUM],
  output logic                          IIR_24_VLD,
  output logic signed [COEFF_WIDTH-1:0] IIR_5_1_OUT [NUM_DENUM],
  output logic                          IIR_5_1_VLD,
  output logic signed [COEFF_WIDTH-1:0] IIR_5_2_OUT [NUM_DENUM],
  output logic                          IIR_5_2_VLD,
  output logic [4:0]                    CIC_R_OUT,
  output logic                          CIC_R_VLD,
  output logic [4:0]                    CTRL,
  output logic [1:0]                    OUT_SEL,
  output logic [2:0]                    COEFF_SEL,
  output logic [2:0]                    STATUS
);
  localparam int unsigned IIR24_BASE     = N_TAP;
  localparam int unsigned IIR51_BASE     = N_TAP + NUM_DENUM;
  localparam int unsigned IIR52_BASE     = N_TAP + 2 * NUM_DENUM;
  localparam int unsigned N_COEF         = N_TAP + 3 * NUM_DENUM;
  localparam int unsigned CIC_ADDR       = N_COEF;
  localparam int unsigned CTRL_BASE      = N_COEF + 1;
  localparam int unsigned OUT_SEL_ADDR   = CTRL_BASE + 5;
  localparam int unsigned COEFF_SEL_ADDR = OUT_SEL_ADDR + 1;
  localparam int unsigned STATUS_ADDR    = COEFF_SEL_ADDR + 1;
  localparam int unsigned IDX_W          = $clog2(N_COEF);
  localparam int unsigned PAD_W          = PDATA_WIDTH - COEFF_WIDTH;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic                          wr_q, wr_d;
  logic [COEFF_WIDTH-1:0]        wdata_q, wdata_d;
  logic [COMP-1:0]               sel_q, sel_d;
  logic [COEFF_WIDTH-1:0]        coef_q [N_COEF];
  logic [COEFF_WIDTH-1:0]        coef_d [N_COEF];
  logic [4:0]                    cic_q, cic_d;
  logic [4:0]                    ctrl_q, ctrl_d;
  logic [1:0]                    out_sel_q, out_sel_d;
  logic [2:0]                    coeff_sel_q, coeff_sel_d;
  logic [2:0]                    status_q, status_d;
  logic [4:0]                    vld_q, vld_d;   // {cic, iir52, iir51, iir24, frac}
  logic [PDATA_WIDTH-1:0]        mrdata_q, mrdata_d;

  logic [31:0]            addr_a;
  logic [IDX_W-1:0]       idx;
  logic                   hit;
  logic                   req;
  logic [PDATA_WIDTH-1:0] rd_val;
  logic [COEFF_WIDTH-1:0] coef_rd;

  assign addr_a = 32'(addr_q);
  assign idx    = addr_q[IDX_W-1:0];
  // MSELx == 0 is not a transfer at all, so the FSM never leaves IDLE for it.
  assign req    = bus.MTRANS && (bus.MSELx != '0);

  // Latched address must be in the map and carry its component select bit.
  always_comb begin
    hit = 1'b0;
    if (addr_a < IIR24_BASE)        hit = sel_q[0];
    else if (addr_a < N_COEF)       hit = sel_q[1];
    else if (addr_a == CIC_ADDR)    hit = sel_q[2];
    else if (addr_a <= STATUS_ADDR) hit = sel_q[3];
  end

  always_comb begin
    rd_val  = '0;
    coef_rd = '0;
    if (addr_a < N_COEF) begin
      coef_rd = coef_q[idx];
      rd_val  = {{PAD_W{coef_rd[COEFF_WIDTH-1]}}, coef_rd};
    end else if (addr_a == CIC_ADDR) begin
      rd_val = PDATA_WIDTH'(cic_q);
    end else if (addr_a < OUT_SEL_ADDR) begin
      rd_val = PDATA_WIDTH'(ctrl_q[3'(addr_a - CTRL_BASE)]);
    end else if (addr_a == OUT_SEL_ADDR) begin
      rd_val = PDATA_WIDTH'(out_sel_q);
    end else if (addr_a == COEFF_SEL_ADDR) begin
      rd_val = PDATA_WIDTH'(coeff_sel_q);
    end else if (addr_a == STATUS_ADDR) begin
      rd_val = PDATA_WIDTH'(status_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    coef_d      = coef_q;
    cic_d       = cic_q;
    ctrl_d      = ctrl_q;
    out_sel_d   = out_sel_q;
    coeff_sel_d = coeff_sel_q;
    status_d    = status_q;
    vld_d       = '0;
    mrdata_d    = mrdata_q;

    case (state_q)
      StIdle: begin
        if (req) begin
          addr_d  = bus.MADDR;
          wr_d    = bus.MWRITE;
          wdata_d = bus.MWDATA;
          sel_d   = bus.MSELx;
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
        if (!wr_q) mrdata_d = hit ? rd_val : '0;
      end
      StAccess: begin
        if (wr_q && hit) begin
          if (addr_a < N_COEF)               coef_d[idx] = wdata_q;
          else if (addr_a == CIC_ADDR)       cic_d = wdata_q[4:0];
          else if (addr_a < OUT_SEL_ADDR)    ctrl_d[3'(addr_a - CTRL_BASE)] = wdata_q[0];
          else if (addr_a == OUT_SEL_ADDR)   out_sel_d = wdata_q[1:0];
          else if (addr_a == COEFF_SEL_ADDR) coeff_sel_d = wdata_q[2:0];
          else                               status_d = wdata_q[2:0];
          vld_d = {addr_a == CIC_ADDR, addr_a == N_COEF - 1, addr_a == IIR52_BASE - 1,
                   addr_a == IIR51_BASE - 1, addr_a == N_TAP - 1};
        end
        if (req) begin
          addr_d  = bus.MADDR;
          wr_d    = bus.MWRITE;
          wdata_d = bus.MWDATA;
          sel_d   = bus.MSELx;
          state_d = StSetup;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      sel_q       <= '0;
      coef_q      <= '{default: '0};
      cic_q       <= '0;
      ctrl_q      <= '0;
      out_sel_q   <= '0;
      coeff_sel_q <= '0;
      status_q    <= '0;
      vld_q       <= '0;
      mrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      coef_q      <= coef_d;
      cic_q       <= cic_d;
      ctrl_q      <= ctrl_d;
      out_sel_q   <= out_sel_d;
      coeff_sel_q <= coeff_sel_d;
      status_q    <= status_d;
      vld_q       <= vld_d;
      mrdata_q    <= mrdata_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_TAP; i++) FRAC_DECI_OUT[i] = coef_q[i];
    for (int i = 0; i < NUM_DENUM; i++) begin
      IIR_24_OUT[i]  = coef_q[IIR24_BASE + i];
      IIR_5_1_OUT[i] = coef_q[IIR51_BASE + i];
      IIR_5_2_OUT[i] = coef_q[IIR52_BASE + i];
    end
  end

  assign bus.MRDATA    = mrdata_q;
  assign FRAC_DECI_VLD = vld_q[0];
  assign IIR_24_VLD    = vld_q[1];
  assign IIR_5_1_VLD   = vld_q[2];
  assign IIR_5_2_VLD   = vld_q[3];
  assign CIC_R_VLD     = vld_q[4];
  assign CIC_R_OUT     = cic_q;
  assign CTRL          = ctrl_q;
  assign OUT_SEL       = out_sel_q;
  assign COEFF_SEL     = coeff_sel_q;
  assign STATUS        = status_q;
endmodule

// File: tb/tb_apb.sv
module tb_apb;
  logic clk;
  logic rst;

  apb_if #(.ADDR_WIDTH(7), .PDATA_WIDTH(32), .COEFF_WIDTH(20), .COMP(4)) bus_if ();

  logic signed [19:0] frac_deci_out [72];
  logic signed [19:0] iir_24_out [5];
  logic signed [19:0] iir_5_1_out [5];
  logic signed [19:0] iir_5_2_out [5];
  logic        frac_deci_vld, iir_24_vld, iir_5_1_vld, iir_5_2_vld, cic_r_vld;
  logic [4:0]  cic_r_out;
  logic [4:0]  ctrl;
  logic [1:0]  out_sel;
  logic [2:0]  coeff_sel;
  logic [2:0]  status;
  logic [4:0]  vld_vec;

  assign vld_vec = {cic_r_vld, iir_5_2_vld, iir_5_1_vld, iir_24_vld, frac_deci_vld};

  apb u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if),
    .FRAC_DECI_OUT (frac_deci_out),
    .FRAC_DECI_VLD (frac_deci_vld),
    .IIR_24_OUT    (iir_24_out),
    .IIR_24_VLD    (iir_24_vld),
    .IIR_5_1_OUT   (iir_5_1_out),
    .IIR_5_1_VLD   (iir_5_1_vld),
    .IIR_5_2_OUT   (iir_5_2_out),
    .IIR_5_2_VLD   (iir_5_2_vld),
    .CIC_R_OUT     (cic_r_out),
    .CIC_R_VLD     (cic_r_vld),
    .CTRL          (ctrl),
    .OUT_SEL       (out_sel),
    .COEFF_SEL     (coeff_sel),
    .STATUS        (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a request for two rising edges, as the master does.
  task automatic put_req(input logic wr, input logic [3:0] sel, input logic [6:0] addr,
                         input logic [19:0] data);
    bus_if.MTRANS = 1'b1;
    bus_if.MWRITE = wr;
    bus_if.MSELx  = sel;
    bus_if.MADDR  = addr;
    bus_if.MWDATA = data;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus_if.MTRANS = 1'b0;
    bus_if.MSELx  = '0;
    @(posedge clk);
    #1;
  endtask

  // Isolated write; returns VLD vector in the cycle after the commit edge.
  task automatic wr_reg(input logic [3:0] sel, input logic [6:0] addr, input logic [19:0] data,
                        output logic [4:0] v);
    put_req(1'b1, sel, addr, data);
    go_idle();
    v = vld_vec;
  endtask

  task automatic rd_reg(input logic [3:0] sel, input logic [6:0] addr);
    put_req(1'b0, sel, addr, 20'h0);
    go_idle();
  endtask

  logic [19:0] frac_exp [72];
  logic [19:0] iir_exp [15];
  logic [4:0]  v;
  logic [4:0]  v_exp;

  initial begin
    rst           = 1'b1;
    bus_if.MTRANS = 1'b0;
    bus_if.MWRITE = 1'b0;
    bus_if.MSELx  = '0;
    bus_if.MADDR  = '0;
    bus_if.MWDATA = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_mrdata", bus_if.MRDATA, 32'h0);
    check_eq("rst_frac0", {12'd0, frac_deci_out[0]}, 32'h0);
    check_eq("rst_frac71", {12'd0, frac_deci_out[71]}, 32'h0);
    check_eq("rst_iir24", {12'd0, iir_24_out[0]}, 32'h0);
    check_eq("rst_iir51", {12'd0, iir_5_1_out[4]}, 32'h0);
    check_eq("rst_iir52", {12'd0, iir_5_2_out[2]}, 32'h0);
    check_eq("rst_cic", {27'd0, cic_r_out}, 32'h0);
    check_eq("rst_ctrl", {27'd0, ctrl}, 32'h0);
    check_eq("rst_outsel", {30'd0, out_sel}, 32'h0);
    check_eq("rst_coeffsel", {29'd0, coeff_sel}, 32'h0);
    check_eq("rst_status", {29'd0, status}, 32'h0);
    check_eq("rst_vld", {27'd0, vld_vec}, 32'h0);

    // Fractional decimator taps: pulse only after the last tap.
    for (int i = 0; i < 72; i++) begin
      frac_exp[i] = 20'($urandom_range(0, 20'hFFFFF));
      wr_reg(4'b0001, 7'(i), frac_exp[i], v);
      v_exp = (i == 71) ? 5'b00001 : 5'b00000;
      check_eq("frac_vld", {27'd0, v}, {27'd0, v_exp});
    end
    go_idle();
    check_eq("frac_vld_drop", {27'd0, vld_vec}, 32'h0);
    for (int i = 0; i < 72; i++) check_eq("frac_val", {12'd0, frac_deci_out[i]}, {12'd0, frac_exp[i]});

    // IIR banks: odd entries negative.
    for (int k = 0; k < 15; k++) begin
      iir_exp[k] = k[0] ? (20'hF0000 | 20'(k)) : 20'(k + 16);
      wr_reg(4'b0010, 7'(72 + k), iir_exp[k], v);
      case (k)
        4:       v_exp = 5'b00010;
        9:       v_exp = 5'b00100;
        14:      v_exp = 5'b01000;
        default: v_exp = 5'b00000;
      endcase
      check_eq("iir_vld", {27'd0, v}, {27'd0, v_exp});
    end
    for (int k = 0; k < 5; k++) begin
      check_eq("iir24_val", {12'd0, iir_24_out[k]}, {12'd0, iir_exp[k]});
      check_eq("iir51_val", {12'd0, iir_5_1_out[k]}, {12'd0, iir_exp[k + 5]});
      check_eq("iir52_val", {12'd0, iir_5_2_out[k]}, {12'd0, iir_exp[k + 10]});
    end

    wr_reg(4'b0100, 7'd87, 20'hFFFF3, v);
    check_eq("cic_val", {27'd0, cic_r_out}, 32'h13);
    check_eq("cic_vld", {27'd0, v}, 32'h10);

    wr_reg(4'b1000, 7'd88, 20'h1, v);
    wr_reg(4'b1000, 7'd89, 20'h0, v);
    wr_reg(4'b1000, 7'd90, 20'h1, v);
    wr_reg(4'b1000, 7'd91, 20'h1, v);
    wr_reg(4'b1000, 7'd92, 20'h0, v);
    check_eq("ctrl_vld", {27'd0, v}, 32'h0);
    wr_reg(4'b1000, 7'd93, 20'h3, v);
    wr_reg(4'b1000, 7'd94, 20'h5, v);
    wr_reg(4'b1000, 7'd95, 20'h6, v);
    check_eq("ctrl_val", {27'd0, ctrl}, 32'h0000000D);
    check_eq("outsel_val", {30'd0, out_sel}, 32'h3);
    check_eq("coeffsel_val", {29'd0, coeff_sel}, 32'h5);
    check_eq("status_val", {29'd0, status}, 32'h6);

    // Back-to-back write then read of the same address.
    put_req(1'b1, 4'b0001, 7'd71, 20'h80001);
    put_req(1'b0, 4'b0001, 7'd71, 20'h0);
    go_idle();
    check_eq("b2b_rd71", bus_if.MRDATA, 32'hFFF80001);
    check_eq("b2b_frac71", {12'd0, frac_deci_out[71]}, 32'h00080001);

    rd_reg(4'b0010, 7'd81);
    check_eq("rd81", bus_if.MRDATA, 32'hFFFF0009);
    rd_reg(4'b0010, 7'd72);
    check_eq("rd72", bus_if.MRDATA, 32'h00000010);
    rd_reg(4'b0100, 7'd87);
    check_eq("rd87", bus_if.MRDATA, 32'h00000013);
    rd_reg(4'b1000, 7'd95);
    check_eq("rd95", bus_if.MRDATA, 32'h00000006);
    rd_reg(4'b1000, 7'd90);
    check_eq("rd90", bus_if.MRDATA, 32'h00000001);
    // A write must leave MRDATA alone.
    wr_reg(4'b1000, 7'd94, 20'h2, v);
    check_eq("wr_keeps_rd", bus_if.MRDATA, 32'h00000001);
    check_eq("coeffsel_rew", {29'd0, coeff_sel}, 32'h2);
    // Rewriting a bank's last address pulses again.
    wr_reg(4'b0100, 7'd87, 20'h00004, v);
    check_eq("cic_vld2", {27'd0, v}, 32'h10);
    check_eq("cic_val2", {27'd0, cic_r_out}, 32'h4);

    // Invalid accesses.
    wr_reg(4'b0010, 7'd10, 20'h12345, v);
    check_eq("bad_sel_wr", {12'd0, frac_deci_out[10]}, {12'd0, frac_exp[10]});
    check_eq("bad_sel_vld", {27'd0, v}, 32'h0);
    wr_reg(4'b1111, 7'd120, 20'h00001, v);
    check_eq("bad_addr_status", {29'd0, status}, 32'h6);
    rd_reg(4'b0010, 7'd71);
    check_eq("bad_sel_rd", bus_if.MRDATA, 32'h0);
    rd_reg(4'b0100, 7'd87);
    rd_reg(4'b1111, 7'd120);
    check_eq("bad_addr_rd", bus_if.MRDATA, 32'h0);
    // MSELx = 0 is no transfer at all.
    put_req(1'b1, 4'b0000, 7'd3, 20'h55555);
    go_idle();
    check_eq("sel0_wr", {12'd0, frac_deci_out[3]}, {12'd0, frac_exp[3]});

    // Inputs changing after the request is latched have no effect.
    bus_if.MTRANS = 1'b1;
    bus_if.MWRITE = 1'b1;
    bus_if.MSELx  = 4'b0001;
    bus_if.MADDR  = 7'd3;
    bus_if.MWDATA = 20'h0ABCD;
    @(posedge clk);
    #1;
    bus_if.MTRANS = 1'b0;
    bus_if.MSELx  = '0;
    bus_if.MADDR  = 7'd4;
    bus_if.MWDATA = 20'h11111;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("latch_addr3", {12'd0, frac_deci_out[3]}, 32'h0000ABCD);
    check_eq("latch_addr4", {12'd0, frac_deci_out[4]}, {12'd0, frac_exp[4]});

    // Reset while the write sits between SETUP and ACCESS.
    bus_if.MTRANS = 1'b1;
    bus_if.MWRITE = 1'b1;
    bus_if.MSELx  = 4'b0001;
    bus_if.MADDR  = 7'd5;
    bus_if.MWDATA = 20'h7FFFF;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus_if.MTRANS = 1'b0;
    bus_if.MSELx  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_mid_frac5", {12'd0, frac_deci_out[5]}, 32'h0);
    check_eq("rst_mid_frac0", {12'd0, frac_deci_out[0]}, 32'h0);
    check_eq("rst_mid_status", {29'd0, status}, 32'h0);
    check_eq("rst_mid_vld", {27'd0, vld_vec}, 32'h0);
    check_eq("rst_mid_mrdata", bus_if.MRDATA, 32'h0);
    wr_reg(4'b0001, 7'd5, 20'h00042, v);
    check_eq("post_rst_wr", {12'd0, frac_deci_out[5]}, 32'h00000042);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
